// File: rtl/fp_half_pkg.sv
// Shared definitions for the packed half-width product word {exp, mant}.
// The mantissa carries an explicit leading one in its top bit.
package fp_half_pkg;
  localparam int EXP_W = 5;
  localparam int MAN_W = 11;
  localparam int FP_W  = EXP_W + MAN_W;

  typedef logic [FP_W-1:0]  fp_t;
  typedef logic [EXP_W-1:0] exp_t;
  typedef logic [MAN_W-1:0] man_t;

  localparam fp_t FP_ZERO = '0;
  localparam fp_t FP_SAT  = '1;

  typedef enum logic [1:0] {IDLE, ALIGN, ADD, NORM} state_e;

  // Operands after alignment: shared exponent and two mantissas on the same scale.
  typedef struct packed {
    exp_t exp;
    man_t man_a;
    man_t man_b;
  } align_t;

  function automatic exp_t fp_exp(input fp_t w);
    return w[FP_W-1 -: EXP_W];
  endfunction

  function automatic man_t fp_man(input fp_t w);
    return w[MAN_W-1:0];
  endfunction
endpackage

// File: rtl/fp_align_add.sv
// Combinational datapath: exponent alignment, mantissa add, carry normalise.
// Each section feeds a separate pipeline register in the top-level FSM.
module fp_align_add
  import fp_half_pkg::*;
(
  input  fp_t              acc,
  input  fp_t              opnd,
  output align_t           al,
  input  align_t           al_in,
  output logic [MAN_W:0]   sum,
  input  exp_t             norm_exp,
  input  logic [MAN_W:0]   norm_sum,
  output fp_t              res,
  output logic             res_ovf
);
  function automatic man_t shr(input man_t m, input exp_t d);
    return (int'(d) >= MAN_W) ? '0 : (m >> d);
  endfunction

  logic a_zero, b_zero;
  exp_t ea, eb;

  // A zero word contributes no mantissa, so the other value passes through exactly.
  always_comb begin
    a_zero = (acc == FP_ZERO);
    b_zero = (opnd == FP_ZERO);
    ea = fp_exp(acc);
    eb = fp_exp(opnd);
    al = '0;
    if (a_zero) begin
      al.exp   = eb;
      al.man_b = fp_man(opnd);
    end else if (b_zero) begin
      al.exp   = ea;
      al.man_a = fp_man(acc);
    end else if (ea >= eb) begin
      al.exp   = ea;
      al.man_a = fp_man(acc);
      al.man_b = shr(fp_man(opnd), ea - eb);
    end else begin
      al.exp   = eb;
      al.man_a = shr(fp_man(acc), eb - ea);
      al.man_b = fp_man(opnd);
    end
  end

  always_comb sum = {1'b0, al_in.man_a} + {1'b0, al_in.man_b};

  always_comb begin
    res     = {norm_exp, norm_sum[MAN_W-1:0]};
    res_ovf = 1'b0;
    if (norm_sum[MAN_W]) begin
      if (norm_exp == '1) begin
        res     = FP_SAT;
        res_ovf = 1'b1;
      end else begin
        res = {norm_exp + exp_t'(1), norm_sum[MAN_W:1]};
      end
    end
  end
endmodule

// File: rtl/fp_prod_accumulator.sv
// Accumulates N_TERMS packed product words, one term per four cycles,
// and pulses out_valid with the sum and sticky saturation flag.
module fp_prod_accumulator
  import fp_half_pkg::*;
#(
  parameter int N_TERMS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FP_W-1:0] in_data,
  input  logic            clear,
  output logic            out_valid,
  output logic [FP_W-1:0] out_data,
  output logic            overflow,
  output logic            busy
);
  localparam int CNT_W = $clog2(N_TERMS + 1);

  state_e             state_q, state_d;
  fp_t                op_q, op_d, acc_q, acc_d, out_data_q, out_data_d;
  align_t             al_q, al_d, al_c;
  logic [MAN_W:0]     sum_q, sum_d, sum_c;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_int_q, ovf_int_d;
  logic               out_valid_q, out_valid_d;
  logic               overflow_q, overflow_d;
  fp_t                res_c;
  logic               res_ovf_c;
  logic               xfer;

  fp_align_add u_dp (
    .acc      (acc_q),
    .opnd     (op_q),
    .al       (al_c),
    .al_in    (al_q),
    .sum      (sum_c),
    .norm_exp (al_q.exp),
    .norm_sum (sum_q),
    .res      (res_c),
    .res_ovf  (res_ovf_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (xfer) state_d = ALIGN;
      ALIGN:   state_d = ADD;
      ADD:     state_d = NORM;
      NORM:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  // clear masks in_ready so a same-cycle offer is never taken.
  always_comb begin
    in_ready = (state_q == IDLE) && !clear;
    busy     = (state_q != IDLE);
  end

  assign xfer = in_valid && in_ready;

  always_comb begin
    op_d        = op_q;
    al_d        = al_q;
    sum_d       = sum_q;
    acc_d       = acc_q;
    count_d     = count_q;
    ovf_int_d   = ovf_int_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    overflow_d  = overflow_q;
    if (clear) begin
      acc_d     = FP_ZERO;
      count_d   = '0;
      ovf_int_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE:  if (xfer) op_d = in_data;
        ALIGN: al_d = al_c;
        ADD:   sum_d = sum_c;
        NORM: begin
          if (count_q == CNT_W'(N_TERMS - 1)) begin
            out_valid_d = 1'b1;
            out_data_d  = res_c;
            overflow_d  = ovf_int_q | res_ovf_c;
            acc_d       = FP_ZERO;
            count_d     = '0;
            ovf_int_d   = 1'b0;
          end else begin
            acc_d     = res_c;
            count_d   = count_q + CNT_W'(1);
            ovf_int_d = ovf_int_q | res_ovf_c;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q        <= FP_ZERO;
      al_q        <= '0;
      sum_q       <= '0;
      acc_q       <= FP_ZERO;
      count_q     <= '0;
      ovf_int_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= FP_ZERO;
      overflow_q  <= 1'b0;
    end else begin
      op_q        <= op_d;
      al_q        <= al_d;
      sum_q       <= sum_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_int_q   <= ovf_int_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign overflow  = overflow_q;
endmodule

// File: tb/tb_fp_prod_accumulator.sv
// Directed bench: a 4-term instance for throughput/latency and a 2-term
// instance for the vector table, clear and asynchronous reset sequences.
module tb_fp_prod_accumulator;
  logic        clk, rst;
  logic        iv  [2];
  logic [15:0] id  [2];
  logic        clr [2];
  logic        ir  [2];
  logic        ov  [2];
  logic [15:0] od  [2];
  logic        ovf [2];
  logic        bsy [2];

  int checks = 0, failures = 0;

  fp_prod_accumulator #(.N_TERMS(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .clear(clr[0]), .out_valid(ov[0]), .out_data(od[0]), .overflow(ovf[0]), .busy(bsy[0]));

  fp_prod_accumulator #(.N_TERMS(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .clear(clr[1]), .out_valid(ov[1]), .out_data(od[1]), .overflow(ovf[1]), .busy(bsy[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [15:0] a, b, res;
    logic        ovf;
  } vec_t;
  vec_t vt[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input int d, input logic [15:0] w);
    int n = 0;
    while (!ir[d] && n < 20) begin @(negedge clk); n++; end
    if (!ir[d]) chk("send_timeout", 32'(n), 32'(0));
    iv[d] = 1'b1; id[d] = w;
    @(negedge clk);
    iv[d] = 1'b0;
  endtask

  // Called at the ALIGN negedge of the last term; result is due three negedges later.
  task automatic wait_result(input int d, input string nm, input logic [15:0] res, input logic o);
    int n = 0;
    while (!ov[d] && n < 20) begin @(negedge clk); n++; end
    chk({nm, "_lat"}, 32'(n), 32'(3));
    chk({nm, "_data"}, 32'(od[d]), 32'(res));
    chk({nm, "_ovf"}, 32'(ovf[d]), 32'(o));
    @(negedge clk);
    chk({nm, "_pulse"}, 32'(ov[d]), 32'(0));
  endtask

  task automatic chk_reset(input int d, input string nm);
    chk({nm, "_ready"}, 32'(ir[d]), 32'(1));
    chk({nm, "_busy"},  32'(bsy[d]), 32'(0));
    chk({nm, "_valid"}, 32'(ov[d]), 32'(0));
    chk({nm, "_data"},  32'(od[d]), 32'(0));
    chk({nm, "_ovf"},   32'(ovf[d]), 32'(0));
  endtask

  initial begin
    logic [15:0] prev;
    int xf;
    vt[0]  = '{"half",        16'h7C00, 16'h7400, 16'h7E00, 1'b0};
    vt[1]  = '{"diff12",      16'h7C00, 16'h1C00, 16'h7C00, 1'b0};
    vt[2]  = '{"diff10",      16'h7C00, 16'h2C00, 16'h7C01, 1'b0};
    vt[3]  = '{"diff11",      16'h7C00, 16'h2400, 16'h7C00, 1'b0};
    vt[4]  = '{"acc_smaller", 16'h7400, 16'h7C00, 16'h7E00, 1'b0};
    vt[5]  = '{"carry_trunc", 16'h7FFF, 16'h7C00, 16'h85FF, 1'b0};
    vt[6]  = '{"saturate",    16'hFC00, 16'hFC00, 16'hFFFF, 1'b1};
    vt[7]  = '{"after_sat",   16'h7C00, 16'h0000, 16'h7C00, 1'b0};
    vt[8]  = '{"zero_zero",   16'h0000, 16'h0000, 16'h0000, 1'b0};
    vt[9]  = '{"zero_acc",    16'h0000, 16'h8400, 16'h8400, 1'b0};
    vt[10] = '{"align_trunc", 16'h7C01, 16'h7401, 16'h7E01, 1'b0};
    vt[11] = '{"one_plus_one",16'h7C00, 16'h7C00, 16'h8400, 1'b0};

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin iv[d] = 1'b0; id[d] = '0; clr[d] = 1'b0; end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset(0, "rst4");
    chk_reset(1, "rst2");

    // Four back-to-back 1.0 terms on the 4-term instance.
    iv[0] = 1'b1; id[0] = 16'h7C00; xf = 0;
    for (int k = 0; k < 16; k++) begin
      chk("b2b_ready", 32'(ir[0]), 32'((k % 4) == 0));
      chk("b2b_novalid", 32'(ov[0]), 32'(0));
      if (ir[0] && iv[0]) xf++;
      @(negedge clk);
      if (xf == 4) iv[0] = 1'b0;
    end
    chk("b2b_xfers", 32'(xf), 32'(4));
    chk("b2b_valid", 32'(ov[0]), 32'(1));
    chk("b2b_data",  32'(od[0]), 32'(16'h8C00));
    chk("b2b_ovf",   32'(ovf[0]), 32'(0));
    @(negedge clk);
    chk("b2b_pulse", 32'(ov[0]), 32'(0));
    chk("b2b_hold",  32'(od[0]), 32'(16'h8C00));

    for (int i = 0; i < 12; i++) begin
      send(1, vt[i].a);
      send(1, vt[i].b);
      wait_result(1, vt[i].nm, vt[i].res, vt[i].ovf);
    end

    // Abort the second term during ADD.
    send(1, 16'h7C00);
    repeat (3) @(negedge clk);
    send(1, 16'h7C00);
    @(negedge clk);
    prev = od[1];
    clr[1] = 1'b1;
    @(negedge clk);
    clr[1] = 1'b0;
    chk("clr_idle", 32'(bsy[1]), 32'(0));
    for (int k = 0; k < 3; k++) begin
      chk("clr_no_valid", 32'(ov[1]), 32'(0));
      chk("clr_hold_data", 32'(od[1]), 32'(prev));
      @(negedge clk);
    end
    clr[1] = 1'b1; iv[1] = 1'b1; id[1] = 16'h7C00;
    #1;
    chk("clr_ready_masked", 32'(ir[1]), 32'(0));
    @(negedge clk);
    clr[1] = 1'b0; iv[1] = 1'b0;
    chk("clr_no_xfer", 32'(bsy[1]), 32'(0));
    send(1, 16'h7C00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_clr_first", 32'(ov[1]), 32'(0));
    end
    send(1, 16'h7C00);
    wait_result(1, "post_clr", 16'h8400, 1'b0);

    // Asynchronous reset while the first term is in NORM.
    send(1, 16'h7C00);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk_reset(1, "async_rst");
    chk_reset(0, "async_rst4");
    #1 rst = 1'b0;
    @(negedge clk);
    send(1, 16'h7C00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_first", 32'(ov[1]), 32'(0));
    end
    send(1, 16'h7400);
    wait_result(1, "post_rst", 16'h7E00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  int cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc > 20000) begin
      $display("FAIL watchdog: got %0d cycles expected under 20000", cyc);
      $fatal(1);
    end
  end
endmodule
